// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
// Holds the transmitter state encoding, the idle level of the serial line
// and the default frame/FIFO parameters used by uart_tx_buffered.
package uart_pkg;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_STOP_BITS  = 1;

  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   push, wdata  write request and data; ignored while full (even on a pop)
//   pop, rdata   read request; rdata shows the head entry combinationally
//   full, empty  occupancy flags decoded from the registered count
//   count        current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_BITS,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_MAX);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
    else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter (8N1 by default, 8E1 with UART_TX_PARITY_EN).
// Bytes enter a FIFO through a valid/ready handshake and are serialised
// LSB-first, one bit period per baud_tick pulse, with back-to-back frames
// sent without an idle gap while the FIFO holds data.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   baud_tick    one-cycle pulse; each pulse ends the current bit period
//   tx_data      byte to send, written when tx_valid && tx_ready
//   tx_valid     tx_data is valid
//   tx_ready     FIFO not full
//   tx           registered serial line, idle high
//   busy         a frame is in progress
//   fifo_count   current FIFO occupancy
// Build option: define UART_TX_PARITY_EN to append an even parity bit
// after the MSB.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int STOP_BITS  = DEF_STOP_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          baud_tick,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] BIT_ONE  = 1;
  // Index of the final stop-bit period (0 for one stop bit, 1 for two).
  localparam logic STOP_LAST = (STOP_BITS == 2);

  tx_state_t            state_q, state_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic                 fifo_push, fifo_pop;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  assign tx_ready  = !fifo_full;
  assign fifo_push = tx_valid && tx_ready;
  assign tx        = tx_q;
  assign busy      = busy_q;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_rdata;
`endif
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            tx_d = LINE_IDLE;
          end
        end
        START: begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
        DATA: begin
          if (bit_cnt_q == BIT_LAST) begin
            stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = LINE_IDLE;
            state_d = STOP;
`endif
          end else begin
            // shift_q[1] becomes the next bit once the register shifts.
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx_d       = LINE_IDLE;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
`endif
        STOP: begin
          if (stop_cnt_q == STOP_LAST) begin
            // Chain straight into the next start bit when data is waiting.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
              parity_d = ^fifo_rdata;
`endif
              tx_d     = 1'b0;
              state_d  = START;
            end else begin
              tx_d    = LINE_IDLE;
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
        default: begin
          tx_d    = LINE_IDLE;
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_q       <= LINE_IDLE;
      busy_q     <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  // Payload registers hold data only and are not reset.
  always_ff @(posedge clk) begin
    shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered (default parameters).
module tb_uart_tx_buffered;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int STOP_BITS  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_TICKS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
  localparam int TICK_DIV    = 16;

  logic                 clk;
  logic                 reset;
  logic                 baud_tick;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx;
  logic                 busy;
  logic [3:0]           fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_BITS-1:0] exp_q [$];
  int   model_cnt = 0;
  int   frames_rx = 0;
  int   starts    = 0;
  int   last_gap  = 0;
  logic last_par  = 1'b0;

  logic tick_en  = 1'b0;
  logic man_tick = 1'b0;
  int   tick_div = 0;

  logic        m_in_frame = 1'b0;
  int          m_idx      = 0;
  int          m_gap      = 0;
  int          m_busy_hi  = 0;
  logic [15:0] m_bits     = '1;

  uart_tx_buffered #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .STOP_BITS  (STOP_BITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_tick  (baud_tick),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_frame(input logic [DATA_BITS-1:0] d);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    f[1+DATA_BITS] = ^d;
`endif
    return f;
  endfunction

  // Tick source: free-running divider, or a manual pulse when disabled.
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (tick_en) begin
        if (tick_div == TICK_DIV - 1) begin
          baud_tick = 1'b1;
          tick_div  = 0;
        end else begin
          baud_tick = 1'b0;
          tick_div++;
        end
      end else begin
        baud_tick = man_tick;
      end
    end
  end

  // Line monitor: samples tx once per bit period and rebuilds frames.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_in_frame = 1'b0;
        m_gap      = 0;
        continue;
      end
      if (baud_tick) begin
        @(negedge clk);
        if (!reset) begin
          if (!m_in_frame) begin
            if (tx == 1'b0) begin
              m_in_frame = 1'b1;
              m_idx      = 0;
              m_bits     = '1;
              m_busy_hi  = 0;
              last_gap   = m_gap;
              m_gap      = 0;
              model_cnt--;
              starts++;
            end else begin
              check_eq("idle_busy", busy, 1'b0);
              m_gap++;
            end
          end
          if (m_in_frame) begin
            m_bits[m_idx] = tx;
            if (busy) m_busy_hi++;
            m_idx++;
            if (m_idx == FRAME_TICKS) begin
              m_in_frame = 1'b0;
              check_eq("frame_expected", exp_q.size() != 0, 1'b1);
              if (exp_q.size() != 0) begin
                logic [DATA_BITS-1:0] e;
                e = exp_q.pop_front();
                check_eq("frame_bits", m_bits, exp_frame(e));
                check_eq("busy_ticks", m_busy_hi, FRAME_TICKS);
                last_par = m_bits[1+DATA_BITS];
                frames_rx++;
              end
            end
          end
        end
      end
    end
  end

  // Caller sits just after a rising edge; the byte is offered for one edge.
  task automatic push_byte(input logic [DATA_BITS-1:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    if (model_cnt < FIFO_DEPTH) begin
      exp_q.push_back(d);
      model_cnt++;
    end
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int c = 0; c < budget && frames_rx < n; c++) @(negedge clk);
    check_eq("wait_frames", frames_rx, n);
  endtask

  initial begin
    int base;
    int s0;
    logic reached;
    tx_valid = 1'b0;
    tx_data  = '0;
    reset    = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_ready", tx_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_count", fifo_count, 0);

    // Single byte
    @(posedge clk); #1;
    push_byte(8'hA5);
    tick_en = 1'b1;
    wait_frames(1, 20 * TICK_DIV);
    repeat (2 * TICK_DIV) @(posedge clk);
    @(negedge clk);
    check_eq("single_busy_low", busy, 1'b0);
    check_eq("single_tx_idle", tx, 1'b1);

    // Back-to-back
    @(posedge clk); #1;
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_frames(3, 40 * TICK_DIV);
    check_eq("b2b_gap", last_gap, 0);

    // Full FIFO, no ticks
    @(posedge clk); #1;
    tick_en = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) push_byte(DATA_BITS'(8'h11 * i + 3));
    @(negedge clk);
    check_eq("full_count", fifo_count, FIFO_DEPTH);
    check_eq("full_ready", tx_ready, 1'b0);
    base = frames_rx;
    s0   = starts;
    @(posedge clk); #1;
    tick_en = 1'b1;
    wait_frames(base + 8, 8 * (FRAME_TICKS + 2) * TICK_DIV);
    repeat (25 * TICK_DIV) @(posedge clk);
    @(negedge clk);
    check_eq("full_frames", starts - s0, 8);
    check_eq("full_drained", fifo_count, 0);

    // Push and pop in the same cycle
    @(posedge clk); #1;
    tick_en = 1'b0;
    @(posedge clk); #1;
    push_byte(8'h5A);
    push_byte(8'hC3);
    push_byte(8'h81);
    @(negedge clk);
    check_eq("pp_pre_count", fifo_count, 3);
    @(posedge clk); #1;
    man_tick = 1'b1;
    push_byte(8'h3E);
    man_tick = 1'b0;
    @(negedge clk);
    check_eq("pp_count", fifo_count, 3);
    check_eq("pp_busy", busy, 1'b1);
    base = frames_rx;
    @(posedge clk); #1;
    tick_en = 1'b1;
    wait_frames(base + 4, 4 * (FRAME_TICKS + 2) * TICK_DIV);

    // Reset during the 4th data bit
    @(posedge clk); #1;
    push_byte(8'h3C);
    push_byte(8'h99);
    reached = 1'b0;
    for (int c = 0; c < 40 * TICK_DIV && !reached; c++) begin
      @(negedge clk);
      reached = m_in_frame && (m_idx == 5);
    end
    check_eq("mid_reached", reached, 1'b1);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_eq("mid_rst_tx", tx, 1'b1);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_count", fifo_count, 0);
    repeat (2) @(posedge clk);
    exp_q.delete();
    model_cnt = 0;
    #1 reset = 1'b0;
    s0 = starts;
    repeat (25 * TICK_DIV) @(posedge clk);
    @(negedge clk);
    check_eq("mid_no_tx", starts - s0, 0);
    check_eq("mid_tx_idle", tx, 1'b1);

`ifdef UART_TX_PARITY_EN
    // Even parity
    base = frames_rx;
    @(posedge clk); #1;
    push_byte(8'h07);
    wait_frames(base + 1, 20 * TICK_DIV);
    check_eq("par_07", last_par, 1'b1);
    @(posedge clk); #1;
    push_byte(8'h03);
    wait_frames(base + 2, 20 * TICK_DIV);
    check_eq("par_03", last_par, 1'b0);
`endif

    check_eq("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
